// File: rtl/shared_adder_sequencer.sv
// Sequencer that time-shares one 8-bit ripple-carry adder between two requesters.
// Each operand is added one byte per cycle, LSB first, with the carry registered between bytes.

module RippleCarryAdder (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [8:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[8];
endmodule

module shared_adder_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [8*WORDS-1:0]   i_req0_a,
  input  logic [8*WORDS-1:0]   i_req0_b,
  input  logic                 i_req0_cin,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [8*WORDS-1:0]   i_req1_a,
  input  logic [8*WORDS-1:0]   i_req1_b,
  input  logic                 i_req1_cin,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [8*WORDS-1:0]   o_rsp_sum,
  output logic                 o_rsp_cout,
  output logic                 o_rsp_id,
  output logic                 o_busy
);
  localparam int W  = 8 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic            r_id;
  logic            r_carry;
  logic            r_cout;
  logic [KW-1:0]   r_k;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_hs0;
  logic            w_hs1;
  logic            w_last_byte;
  logic [7:0]      w_add_a;
  logic [7:0]      w_add_b;
  logic [7:0]      w_add_sum;
  logic            w_add_cout;

  // Round-robin: on contention the requester that was not served last wins.
  assign w_grant0    = i_req0_valid & (~i_req1_valid | r_last);
  assign w_grant1    = i_req1_valid & (~i_req0_valid | ~r_last);
  assign w_hs0       = o_req0_ready & i_req0_valid;
  assign w_hs1       = o_req1_ready & i_req1_valid;
  assign w_last_byte = (r_k == KW'(WORDS - 1));
  assign w_add_a     = r_a[8*r_k +: 8];
  assign w_add_b     = r_b[8*r_k +: 8];

  RippleCarryAdder u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_comb begin
    w_next       = r_state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_rst) begin
          o_req0_ready = w_grant0;
          o_req1_ready = w_grant1;
        end
        if (w_grant0 | w_grant1) w_next = S_ADD;
      end
      S_ADD:   if (w_last_byte) w_next = S_DONE;
      S_DONE:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs0 | w_hs1) begin
        r_a     <= w_hs1 ? i_req1_a   : i_req0_a;
        r_b     <= w_hs1 ? i_req1_b   : i_req0_b;
        r_carry <= w_hs1 ? i_req1_cin : i_req0_cin;
        r_id    <= w_hs1;
        r_last  <= w_hs1;
        r_k     <= '0;
      end else if (r_state == S_ADD) begin
        r_sum[8*r_k +: 8] <= w_add_sum;
        r_carry           <= w_add_cout;
        r_k               <= r_k + KW'(1);
        if (w_last_byte) r_cout <= w_add_cout;
      end
    end
  end

  assign o_rsp_valid = (r_state == S_DONE);
  assign o_rsp_sum   = r_sum;
  assign o_rsp_cout  = r_cout;
  assign o_rsp_id    = r_id;
  assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_shared_adder_sequencer.sv
// Bench for shared_adder_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of arbitration, latency and sums.

module tb_shared_adder_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         c0 = 1'b0, c1 = 1'b0;
  logic         rsp_ready = 1'b1;
  logic         rdy0, rdy1, rsp_valid, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_sum;

  shared_adder_sequencer #(.WORDS(WORDS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_cin(c0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_cin(c1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_sum(rsp_sum),
    .o_rsp_cout(rsp_cout), .o_rsp_id(rsp_id), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rsp = 0;
  bit chk_en = 1'b0;
  bit hs0, hs1, rsp_hs;
  int acc_id_q[$];
  int acc_cyc_q[$];

  // Transaction-level model: idle / counting down WORDS cycles / holding a result.
  bit           m_idle = 1'b1;
  bit           m_done = 1'b0;
  int           m_cnt  = 0;
  bit           m_last = 1'b1;
  logic [W-1:0] m_sum  = '0;
  bit           m_cout = 1'b0;
  bit           m_id   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit e0, e1;
    logic [W:0] full;
    e0 = 1'b0;
    e1 = 1'b0;
    if (m_idle && !rst) begin
      e0 = v0 && (!v1 || m_last);
      e1 = v1 && (!v0 || !m_last);
    end
    hs0    = v0 & rdy0;
    hs1    = v1 & rdy1;
    rsp_hs = rsp_valid & rsp_ready;
    if (chk_en) begin
      chk("ready0", rdy0, e0);
      chk("ready1", rdy1, e1);
      chk("one_ready", rdy0 & rdy1, 0);
      chk("busy", busy, !m_idle);
      chk("rsp_valid", rsp_valid, m_done);
      if (m_done) begin
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_cout", rsp_cout, m_cout);
        chk("rsp_id", rsp_id, m_id);
      end
    end
    if (hs0 || hs1) begin
      acc_id_q.push_back(hs1 ? 1 : 0);
      acc_cyc_q.push_back(cyc);
    end
    if (rsp_hs) n_rsp++;

    if (rst) begin
      m_idle = 1'b1; m_done = 1'b0; m_cnt = 0; m_last = 1'b1;
    end else if (m_idle) begin
      if (e0 || e1) begin
        full   = e1 ? ({1'b0, a1} + {1'b0, b1} + (W+1)'(c1))
                    : ({1'b0, a0} + {1'b0, b0} + (W+1)'(c0));
        m_sum  = full[W-1:0];
        m_cout = full[W];
        m_id   = e1;
        m_last = e1;
        m_idle = 1'b0;
        m_cnt  = WORDS;
      end
    end else if (!m_done) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end else if (rsp_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(output bit got0, output bit got1);
    int n;
    n = 0;
    got0 = 1'b0;
    got1 = 1'b0;
    while (n < 60) begin
      tick();
      n++;
      if (hs0 || hs1) begin
        got0 = hs0;
        got1 = hs1;
        break;
      end
    end
    if (!(got0 || got1)) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || v0 || v1) && n < 200) begin
      if (hs0) v0 = 1'b0;
      if (hs1) v1 = 1'b0;
      tick();
      n++;
    end
    if (hs0) v0 = 1'b0;
    if (hs1) v1 = 1'b0;
    if (busy) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bit g0, g1;
    int n, base, budget;

    // Reset
    tick(); chk_en = 1'b1; tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_ready0", rdy0, 0);
    rst = 1'b0;
    tick();

    // Single add on requester 0
    v0 = 1'b1; a0 = 32'h0000_00FF; b0 = 32'h0000_0001; c0 = 1'b0;
    wait_hs(g0, g1);
    chk("t1_grant0", g0, 1);
    v0 = 1'b0; a0 = '0;
    wait_rsp_valid(n);
    chk("t1_latency", n, 4);
    chk("t1_sum", rsp_sum, 32'h0000_0100);
    chk("t1_cout", rsp_cout, 0);
    chk("t1_id", rsp_id, 0);
    drain();

    // Full ripple on requester 1
    v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h0; c1 = 1'b1;
    wait_hs(g0, g1);
    v1 = 1'b0;
    wait_rsp_valid(n);
    chk("t2_sum", rsp_sum, 32'h0);
    chk("t2_cout", rsp_cout, 1);
    chk("t2_id", rsp_id, 1);
    drain();

    // Contention with both requesters continuously valid
    acc_id_q.delete(); acc_cyc_q.delete();
    v0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h0101_0101; c0 = 1'b0;
    v1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'h8000_0000; c1 = 1'b1;
    n = 0;
    while (acc_id_q.size() < 4 && n < 100) begin tick(); n++; end
    v0 = 1'b0; v1 = 1'b0;
    chk("t3_accepts", acc_id_q.size(), 4);
    if (acc_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_id_order", acc_id_q[i], i % 2);
      for (int i = 1; i < 4; i++) chk("t3_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 6);
    end
    drain();

    // Backpressure in DONE
    rsp_ready = 1'b0;
    v0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h1111_1111; c0 = 1'b1;
    wait_hs(g0, g1);
    v0 = 1'b0;
    v1 = 1'b1; a1 = 32'h0000_0003; b1 = 32'h0000_0004; c1 = 1'b0;
    wait_rsp_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("t4_sum", rsp_sum, 32'h2345_678A);
      chk("t4_cout", rsp_cout, 0);
      chk("t4_id", rsp_id, 0);
      chk("t4_busy", busy, 1);
      chk("t4_ready1", rdy1, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_released", rsp_valid, 0);
    chk("t4_idle", busy, 0);
    drain();

    // Reset during byte 2
    v0 = 1'b1; a0 = 32'hDEAD_BEEF; b0 = 32'h0BAD_F00D; c0 = 1'b1;
    wait_hs(g0, g1);
    v0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_sum", rsp_sum, 0);
    chk("t5_cout", rsp_cout, 0);
    chk("t5_id", rsp_id, 0);
    v0 = 1'b1; v1 = 1'b1;
    a0 = 32'h0000_0010; b0 = 32'h0000_0020; c0 = 1'b0;
    a1 = 32'h0000_0030; b1 = 32'h0000_0040; c1 = 1'b0;
    wait_hs(g0, g1);
    chk("t5_first_grant0", g0, 1);
    chk("t5_first_grant1", g1, 0);
    v0 = 1'b0;
    drain();

    // Randomized traffic
    base   = n_rsp;
    budget = 0;
    while (n_rsp < base + 300 && budget < 20000) begin
      if (!v0 || hs0) begin
        v0 = ($urandom_range(1, 0) == 1);
        a0 = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b0 = 32'($urandom);
        c0 = 1'($urandom);
      end
      if (!v1 || hs1) begin
        v1 = ($urandom_range(1, 0) == 1);
        a1 = 32'($urandom);
        b1 = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        c1 = 1'($urandom);
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      tick();
      budget++;
    end
    if (n_rsp < base + 300) chk("random_timeout", n_rsp - base, 300);
    rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/shared_adder_sequencer.md
# shared_adder_sequencer

Time-shares one 8-bit `RippleCarryAdder` between two requesters. Each request is an operand-wide add of `8*WORDS` bits, executed one byte per cycle, least-significant byte first, with the carry registered between bytes. A round-robin arbiter grants requests, and a valid/ready response port returns the sum. The block sits between client logic and the shared adder datapath, so wide additions need no wide adder.

## Interface
- `WORDS`, default 4: bytes per operand; operand width `W = 8*WORDS`; must be ≥ 1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an add pending.
- `req0_ready`  out  1  requester 0 accepted this cycle (handshake = valid & ready).
- `req0_a`, `req0_b`  in  W  operands of requester 0.
- `req0_cin`  in  1  carry-in of requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result (handshake = valid & ready).
- `rsp_sum`  out  W  `(a + b + cin) mod 2^W`.
- `rsp_cout`  out  1  carry out of the most significant byte.
- `rsp_id`  out  1  requester that issued the result.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Instantiates exactly one 8-bit `RippleCarryAdder` (`a`, `b`, `cin` → `sum`, `cout`). No other adder is used.
- **States:** IDLE, ADD, DONE.
- **IDLE: arbitration.**
  - Grant logic is combinational from `req*_valid` and a 1-bit `last` pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester ≠ `last` is granted.
  - `reqX_ready` = (state == IDLE) & grant == X. At most one ready is high per cycle.
  - On handshake:
    - latch `a`, `b`, `cin` into operand registers;
    - `id` ← X, `last` ← X, byte index `k` ← 0, carry register ← `cin`;
    - go to ADD.
- **ADD:**
  - Adder inputs are `a[8k+7:8k]`, `b[8k+7:8k]`, carry register.
  - Each edge: result byte k ← adder `sum`; carry ← adder `cout`; k ← k+1.
  - After the byte with k = WORDS-1 is stored, go to DONE, with `rsp_cout` = final carry.
- **DONE:**
  - `rsp_valid` = 1; `rsp_sum`, `rsp_cout`, `rsp_id` held stable.
  - When `rsp_ready` is high, go to IDLE.
  - No request is accepted in the cycle the response handshake completes.
- **Requester rules:**
  - A requester holds `valid` and operands until its ready is seen.
  - Operands may change freely after acceptance; they are latched.
- **Arithmetic:** unsigned, wraps modulo 2^W. `rsp_cout` equals bit W of the full (W+1)-bit sum.
- **Reset** (any state, including mid-ADD or DONE):
  - The operation is aborted and no response is produced.
  - state = IDLE, `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0, `busy` = 0.
  - `last` = 1, so requester 0 wins the first simultaneous request. Carry, k and operand registers are cleared to 0.
  - `req*_ready` is 0 while `rst` is high.

## Timing
- **Accept edge E:** state → ADD, `busy` = 1 after E.
- **Byte i** (i = 0..WORDS-1) is computed during the cycle after edge E+i and stored at edge E+i+1.
- **`rsp_valid`:** rises after edge E+WORDS, i.e. WORDS cycles after acceptance (4 for default).
- **`rsp_ready` already high** when `rsp_valid` rises: response taken at edge E+WORDS+1 → IDLE.
  - The next accept is at edge E+WORDS+2 at the earliest.
  - Peak throughput is one add per WORDS+2 cycles.
- **Backpressure:** `rsp_ready` low holds DONE indefinitely; both `req*_ready` stay 0.
- **Single-byte case:** WORDS = 1 gives one ADD cycle.

## Test plan
- **Single add, requester 0:** after reset, req0 a=0x000000FF, b=0x00000001, cin=0 →
  - `rsp_valid` 4 cycles after accept;
  - `rsp_sum`=0x00000100, `rsp_cout`=0, `rsp_id`=0.
- **Full ripple:** req1 a=0xFFFFFFFF, b=0x00000000, cin=1 → `rsp_sum`=0x00000000, `rsp_cout`=1, `rsp_id`=1.
- **Contention:** both valid continuously, `rsp_ready`=1 →
  - grants alternate, with ids 0,1,0,1;
  - never two readies in one cycle;
  - accepts exactly 6 cycles apart.
- **Backpressure:** `rsp_ready` held 0 for 5 cycles in DONE →
  - sum, cout and id unchanged;
  - `busy`=1, both readies 0;
  - completes on the first cycle `rsp_ready`=1.
- **Reset mid-ADD:** assert `rst` during byte 2 →
  - next cycle `busy`=0, `rsp_valid`=0, all `rsp_*` = 0;
  - no stale response;
  - then both requesters valid → requester 0 granted first.
- **Randomized:** 256+ random (a, b, cin, requester, `rsp_ready` stalls) → every response matches `{cout,sum} = a+b+cin` and the issuing id.
